// File: rtl/shape_int_pkg.sv
// Shared widths, channel/state types and saturation limits for the shaping-integrator scheduler.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package shape_int_pkg;
    localparam int N   = 16;
    localparam int NCH = 4;
    localparam int B1  = 1;
    localparam int CW  = $clog2(NCH);
    // Working width for tmp + D - y1 before clipping (two guard bits).
    localparam int SW  = N + 2;

    typedef logic signed [N-1:0] samp_t;
    typedef logic [CW-1:0]       chan_t;

    typedef struct packed {
        samp_t tmp;
        samp_t y1;
    } chan_state_t;

    localparam samp_t MPOS = {1'b0, {(N-1){1'b1}}};
    localparam samp_t MNEG = {1'b1, {(N-1){1'b0}}};

    function automatic logic signed [SW-1:0] sext(input samp_t v);
        return {{(SW-N){v[N-1]}}, v};
    endfunction
endpackage

// File: rtl/shape_int_sched_if.sv
// Sample-request, clear and result bundle between the front ends and the shared integrator.
// Latency: none (wiring only).
// Backpressure: in_ready grants per channel; the result side has none.
interface shape_int_sched_if;
    import shape_int_pkg::*;

    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [NCH*N-1:0] in_data;
    logic             clr_req;
    chan_t            clr_ch;
    logic             out_valid;
    chan_t            out_ch;
    samp_t            out_data;

    modport master (
        output in_valid, in_data, clr_req, clr_ch,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_data, clr_req, clr_ch,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/shape_int_step.sv
// One shaping-integrator step: nudge a zero y1 toward tmp's sign, accumulate, clip, shift.
// Latency: combinational.
// Backpressure: none.
module shape_int_step
    import shape_int_pkg::*;
(
    input  samp_t d_i,
    input  samp_t tmp_i,
    input  samp_t y1_i,
    output samp_t tmp_o,
    output samp_t y1_o,
    output logic  sat_o
);
    localparam logic signed [SW-1:0] WMAX = {{(SW-N){1'b0}}, MPOS};
    localparam logic signed [SW-1:0] WMIN = {{(SW-N){1'b1}}, MNEG};

    logic signed [SW-1:0] y1_eff;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shr;
    logic                 tmp_clip;
    logic                 y1_clip;

    // Nudge, wide accumulate, clip tmp, then derive y1 from the clipped tmp.
    always_comb begin
        y1_eff = sext(y1_i);
        if (y1_i == '0 && tmp_i != '0) begin
            y1_eff = tmp_i[N-1] ? '1 : SW'(1);
        end
        sum = sext(tmp_i) + sext(d_i) - y1_eff;

        tmp_o    = sum[N-1:0];
        tmp_clip = 1'b0;
        if (sum > WMAX) begin
            tmp_o    = MPOS;
            tmp_clip = 1'b1;
        end else if (sum < WMIN) begin
            tmp_o    = MNEG;
            tmp_clip = 1'b1;
        end

        shr     = sext(tmp_o) >>> B1;
        y1_o    = shr[N-1:0];
        y1_clip = 1'b0;
        if (shr > WMAX) begin
            y1_o    = MPOS;
            y1_clip = 1'b1;
        end else if (shr < WMIN) begin
            y1_o    = MNEG;
            y1_clip = 1'b1;
        end

        sat_o = tmp_clip | y1_clip;
    end
endmodule

// File: rtl/shape_int_sched.sv
// Round-robin shared integrator for NCH channels; SHAPE_SCHED_SATCNT_EN adds per-channel clip counters.
// Latency: 2 cycles from transfer edge to out_valid; one grant per cycle, same channel never back-to-back.
// Backpressure: in_ready is a combinational one-hot grant; results are never stalled.
module shape_int_sched
    import shape_int_pkg::*;
(
    input  logic             C,
    input  logic             CLRn,
    shape_int_sched_if.slave io
`ifdef SHAPE_SCHED_SATCNT_EN
    ,
    output logic [NCH*8-1:0] sat_cnt
`endif
);
    chan_state_t    bank_q [NCH];
    chan_state_t    bank_d [NCH];
    chan_t          ptr_q, ptr_d;
    logic [NCH-1:0] last_q, last_d;
    logic [NCH-1:0] mask, elig, grant;
    logic           found;
    chan_t          gidx, idx;

    logic           s1_vld_q, s1_vld_d;
    chan_t          s1_ch_q, s1_ch_d;
    samp_t          s1_dat_q, s1_dat_d;
    logic           s2_vld_q, s2_vld_d;
    chan_t          s2_ch_q, s2_ch_d;
    samp_t          s2_dat_q, s2_dat_d;
    chan_state_t    s2_st_q, s2_st_d;
    logic           out_vld_q, out_vld_d;
    chan_t          out_ch_q, out_ch_d;
    samp_t          out_dat_q, out_dat_d;

    samp_t          tmp_n, y1_n;
    logic           sat_n;

    // Arbiter: search from ptr, skipping last cycle's grant (its write-back is still pending) and the channel being cleared.
    always_comb begin
        mask = last_q;
        if (io.clr_req) mask[io.clr_ch] = 1'b1;
        elig  = io.in_valid & ~mask;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = chan_t'((int'(ptr_q) + k) % NCH);
            if (!found && elig[idx]) begin
                found       = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
        if (!CLRn) begin
            grant = '0;
            found = 1'b0;
        end
        ptr_d  = found ? chan_t'((int'(gidx) + 1) % NCH) : ptr_q;
        last_d = grant;
    end

    assign io.in_ready = grant;

    shape_int_step u_step (
        .d_i   (s2_dat_q),
        .tmp_i (s2_st_q.tmp),
        .y1_i  (s2_st_q.y1),
        .tmp_o (tmp_n),
        .y1_o  (y1_n),
        .sat_o (sat_n)
    );

    // Pipeline: S1 captures the sample, S2 captures the bank read, the output stage takes the step result.
    always_comb begin
        s1_vld_d  = found;
        s1_ch_d   = gidx;
        s1_dat_d  = io.in_data[int'(gidx)*N +: N];
        s2_vld_d  = s1_vld_q;
        s2_ch_d   = s1_ch_q;
        s2_dat_d  = s1_dat_q;
        s2_st_d   = bank_q[s1_ch_q];
        out_vld_d = s2_vld_q;
        out_ch_d  = s2_vld_q ? s2_ch_q : out_ch_q;
        out_dat_d = s2_vld_q ? tmp_n   : out_dat_q;
    end

    // State bank: S2 write-back, then a clear on the same channel overrides it.
    always_comb begin
        bank_d = bank_q;
        if (s2_vld_q) bank_d[s2_ch_q] = '{tmp: tmp_n, y1: y1_n};
        if (io.clr_req) bank_d[io.clr_ch] = '0;
    end

    // All scheduler, pipeline and bank registers.
    always_ff @(posedge C or negedge CLRn) begin
        if (!CLRn) begin
            ptr_q     <= '0;
            last_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_dat_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_dat_q  <= '0;
            s2_st_q   <= '0;
            out_vld_q <= 1'b0;
            out_ch_q  <= '0;
            out_dat_q <= '0;
            for (int i = 0; i < NCH; i++) bank_q[i] <= '0;
        end else begin
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            s1_vld_q  <= s1_vld_d;
            s1_ch_q   <= s1_ch_d;
            s1_dat_q  <= s1_dat_d;
            s2_vld_q  <= s2_vld_d;
            s2_ch_q   <= s2_ch_d;
            s2_dat_q  <= s2_dat_d;
            s2_st_q   <= s2_st_d;
            out_vld_q <= out_vld_d;
            out_ch_q  <= out_ch_d;
            out_dat_q <= out_dat_d;
            bank_q    <= bank_d;
        end
    end

    assign io.out_valid = out_vld_q;
    assign io.out_ch    = out_ch_q;
    assign io.out_data  = out_dat_q;

`ifdef SHAPE_SCHED_SATCNT_EN
    logic [7:0] cnt_q [NCH];
    logic [7:0] cnt_d [NCH];

    // Count clipped steps per channel, sticking at 255; a clear for the channel wins.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_vld_q && sat_n && cnt_q[s2_ch_q] != 8'hFF) begin
            cnt_d[s2_ch_q] = cnt_q[s2_ch_q] + 8'd1;
        end
        if (io.clr_req) cnt_d[io.clr_ch] = '0;
    end

    // Clip counter registers.
    always_ff @(posedge C or negedge CLRn) begin
        if (!CLRn) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        sat_cnt = '0;
        for (int i = 0; i < NCH; i++) sat_cnt[i*8 +: 8] = cnt_q[i];
    end
`else
    // Without counters the clip flag has no consumer.
    logic unused_sat;
    assign unused_sat = sat_n;
`endif
endmodule
